// File: rtl/fp32_half_packer.sv
// Streaming fp32 -> fp16 (round-to-nearest-even) converter that packs LANES halves
// per output vector behind a fill/hold controller and a one-entry output register.
module fp32_half_packer #(
   parameter int LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [16*LANES-1:0]  out_data,
   output logic [LANES-1:0]     out_mask,
   output logic [3:0]           out_flags
);

   localparam int CNT_W = $clog2(LANES);

   typedef enum logic {FILL, HOLD} state_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt;
   logic [16*LANES-1:0]   pack_data, merged_data, src_data;
   logic [LANES-1:0]      pack_mask, merged_mask, src_mask;
   logic [3:0]            pack_flags, merged_flags, src_flags;

   // ---------------------------------------------------------------- conversion
   logic        sgn;
   logic [7:0]  exp32;
   logic [22:0] man;
   logic [4:0]  exp16;
   logic        guard, sticky, rnd;
   logic [14:0] rounded;
   logic [15:0] half;
   logic [3:0]  cflags;   // {invalid, overflow, underflow, inexact}

   assign sgn     = in_data[31];
   assign exp32   = in_data[30:23];
   assign man     = in_data[22:0];
   // Rebias 127 -> 15 is a subtraction of 112; modulo 32 that is just "- 16".
   assign exp16   = exp32[4:0] - 5'd16;
   assign guard   = man[12];
   assign sticky  = |man[11:0];
   assign rnd     = guard & (sticky | man[13]);
   assign rounded = {exp16, man[22:13]} + {14'd0, rnd};

   // NOTE: every output of a combinational block gets a default first, otherwise
   // a path that skips an assignment infers a latch.
   always_comb begin
      half   = {sgn, 15'h0000};
      cflags = 4'b0000;
      if (exp32 == 8'hff) begin
         if (man != '0) begin
            half      = {sgn, 5'h1f, 1'b1, man[21:13]};
            cflags[3] = ~man[22];
         end else begin
            half = {sgn, 5'h1f, 10'h000};
         end
      end else if (exp32 == 8'h00) begin
         if (man != '0) cflags[1:0] = 2'b11;
      end else if (exp32 > 8'd142) begin
         half   = {sgn, 5'h1f, 10'h000};
         cflags = 4'b0101;
      end else if (exp32 >= 8'd113) begin
         cflags[0] = guard | sticky;
         if (rounded[14:10] == 5'h1f) begin
            half      = {sgn, 5'h1f, 10'h000};
            cflags[2] = 1'b1;
         end else begin
            half = {sgn, rounded};
         end
      end else begin
         cflags[1:0] = 2'b11;
      end
   end

   // ---------------------------------------------------------------- packing
   logic accept, last_lane, complete, out_free, load_out;

   assign in_ready  = (state == FILL);
   assign accept    = in_valid & in_ready;
   assign last_lane = (cnt == CNT_W'(LANES - 1));
   assign complete  = accept & (last_lane | in_last);
   assign out_free  = ~out_valid | out_ready;

   always_comb begin
      merged_data                     = pack_data;
      merged_data[{cnt, 4'b0000} +: 16] = half;
      merged_mask                     = pack_mask;
      merged_mask[cnt]                = 1'b1;
      merged_flags                    = pack_flags | cflags;
   end

   // In HOLD the finished vector already sits in the pack register.
   assign src_data  = (state == HOLD) ? pack_data  : merged_data;
   assign src_mask  = (state == HOLD) ? pack_mask  : merged_mask;
   assign src_flags = (state == HOLD) ? pack_flags : merged_flags;

   always_comb begin
      state_next = state;
      load_out   = 1'b0;
      case (state)
         FILL: if (complete) begin
            if (out_free) load_out   = 1'b1;
            else          state_next = HOLD;
         end
         HOLD: if (out_free) begin
            load_out   = 1'b1;
            state_next = FILL;
         end
         default: state_next = FILL;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (accept) cnt <= complete ? '0 : cnt + 1'b1;
      end
   end

   // NOTE: the pack register is reset, not just overwritten, so that a reset
   // mid-vector cannot leak stale lanes into the next vector's zero padding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pack_data  <= '0;
         pack_mask  <= '0;
         pack_flags <= '0;
      end else if (load_out) begin
         pack_data  <= '0;
         pack_mask  <= '0;
         pack_flags <= '0;
      end else if (accept) begin
         pack_data  <= merged_data;
         pack_mask  <= merged_mask;
         pack_flags <= merged_flags;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= '0;
         out_flags <= '0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_data  <= src_data;
         out_mask  <= src_mask;
         out_flags <= src_flags;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp32_half_packer.sv
// Self-checking bench for fp32_half_packer: directed cases plus randomized traffic
// scored against an arithmetic reference model and an expected-vector queue.
module tb_fp32_half_packer;

   localparam int LANES = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid, in_ready, in_last;
   logic [31:0]         in_data;
   logic                out_valid, out_ready;
   logic [16*LANES-1:0] out_data;
   logic [LANES-1:0]    out_mask;
   logic [3:0]          out_flags;

   fp32_half_packer #(.LANES(LANES)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mask(out_mask), .out_flags(out_flags)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   typedef struct {
      logic [63:0] data;
      logic [3:0]  mask;
      logic [3:0]  flags;
   } vec_t;

   vec_t        exp_q[$];
   int          m_cnt = 0;
   logic [63:0] m_data = '0;
   logic [3:0]  m_mask = '0;
   logic [3:0]  m_flags = '0;

   // Rounds via integer division of the full 24-bit significand.
   function automatic void ref_half(input logic [31:0] x, output logic [15:0] h,
                                    output logic [3:0] f);
      logic s;
      int   e, m, sig, q, r, ex;
      s = x[31];
      e = int'(x[30:23]);
      m = int'(x[22:0]);
      f = 4'b0000;
      if (e == 255) begin
         if (m != 0) begin
            h    = {s, 5'h1f, 1'b1, x[21:13]};
            f[3] = ~x[22];
         end else h = {s, 15'h7c00};
      end else if (e == 0) begin
         h = {s, 15'h0000};
         if (m != 0) f = 4'b0011;
      end else if (e - 127 > 15) begin
         h = {s, 15'h7c00};
         f = 4'b0101;
      end else if (e - 127 < -14) begin
         h = {s, 15'h0000};
         f = 4'b0011;
      end else begin
         sig = (1 << 23) + m;
         q   = sig / 8192;
         r   = sig % 8192;
         if (r > 4096 || (r == 4096 && q % 2 == 1)) q++;
         ex = e - 127 + 15;
         if (q == 2048) begin q = 1024; ex++; end
         if (r != 0) f[0] = 1'b1;
         if (ex >= 31) begin
            h    = {s, 15'h7c00};
            f[2] = 1'b1;
         end else h = {s, 5'(ex), 10'(q - 1024)};
      end
   endfunction

   // Scoreboard: retires output handshakes, checks stall stability, models accepts.
   logic        stall = 1'b0;
   logic [71:0] held;
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         m_cnt = 0; m_data = '0; m_mask = '0; m_flags = '0;
         stall = 1'b0;
      end else begin
         if (stall && out_valid) check("hold_stable", {out_data, out_mask, out_flags}, held);
         if (out_valid && out_ready) begin
            check("vec_expected", 80'(exp_q.size() != 0), 80'd1);
            if (exp_q.size() != 0) begin
               vec_t v;
               v = exp_q.pop_front();
               check("vec_data",  out_data,  v.data);
               check("vec_mask",  out_mask,  v.mask);
               check("vec_flags", out_flags, v.flags);
            end
         end
         stall = out_valid && !out_ready;
         held  = {out_data, out_mask, out_flags};
         if (in_valid && in_ready) begin
            logic [15:0] h;
            logic [3:0]  f;
            ref_half(in_data, h, f);
            m_data[m_cnt*16 +: 16] = h;
            m_mask[m_cnt] = 1'b1;
            m_flags |= f;
            if (m_cnt == LANES - 1 || in_last) begin
               exp_q.push_back('{m_data, m_mask, m_flags});
               m_cnt = 0; m_data = '0; m_mask = '0; m_flags = '0;
            end else m_cnt++;
         end
      end
   end

   // ------------------------------------------------------------ stimulus helpers
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Starts and returns 1 time unit after a rising edge; the element is accepted
   // at the edge just before return.
   task automatic send(input logic [31:0] d, input logic l);
      bit ok = 1'b0;
      in_valid = 1'b1; in_data = d; in_last = l;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("in_ready_timeout", 80'(ok), 80'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_data"},  out_data,  64'h0);
      check({tag, "_out_mask"},  out_mask,  4'h0);
      check({tag, "_out_flags"}, out_flags, 4'h0);
      check({tag, "_in_ready"},  in_ready,  1'b1);
   endtask

   task automatic reset_pulse(input string tag);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs(tag);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_fp();
      logic [31:0] x;
      x = $urandom;
      case ($urandom_range(0, 4))
         0: ;
         1: x[30:23] = 8'($urandom_range(108, 147));
         2: begin
            x[30:23] = 8'($urandom_range(110, 145));
            case ($urandom_range(0, 3))
               0: x[12:0] = 13'h1000;
               1: x[12:0] = 13'h0000;
               2: x[12:0] = 13'h1001;
               default: x[12:0] = 13'h0fff;
            endcase
         end
         3: x[30:23] = $urandom_range(0, 1) ? 8'hff : 8'h00;
         default: begin x[30:23] = 8'd142; x[22:12] = 11'h7ff; end
      endcase
      return x;
   endfunction

   // ------------------------------------------------------------ directed cases
   typedef struct {
      logic [31:0] din;
      logic [15:0] half;
      logic [3:0]  flags;
   } conv_t;

   conv_t conv_tab[8] = '{
      '{32'h3F801000, 16'h3C00, 4'b0001},
      '{32'h3F803000, 16'h3C02, 4'b0001},
      '{32'h477FF000, 16'h7C00, 4'b0101},
      '{32'h3FFFF000, 16'h4000, 4'b0001},
      '{32'h7FC00000, 16'h7E00, 4'b0000},
      '{32'h7F800001, 16'h7E00, 4'b1000},
      '{32'hFF800000, 16'hFC00, 4'b0000},
      '{32'h2EDBE6FF, 16'h0000, 4'b0011}
   };

   logic [31:0] vec_a[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
   logic [31:0] vec_b[4] = '{32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000};
   localparam logic [63:0] HALF_A = 64'h4400_4200_4000_3C00;
   localparam logic [63:0] HALF_B = 64'hC400_C200_C000_BC00;

   bit rand_done = 1'b0;

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b1;
      step(1);

      // Basic full vector, output one cycle after the fourth accept.
      send(32'h3F800000, 1'b0);
      send(32'hBF800000, 1'b0);
      send(32'h477FE000, 1'b0);
      check("basic_not_early", out_valid, 1'b0);
      send(32'h00000000, 1'b0);
      check("basic_valid", out_valid, 1'b1);
      check("basic_data",  out_data,  64'h0000_7BFF_BC00_3C00);
      check("basic_mask",  out_mask,  4'hF);
      check("basic_flags", out_flags, 4'h0);

      // Rounding and special values, each flushed alone via in_last.
      foreach (conv_tab[i]) begin
         send(conv_tab[i].din, 1'b1);
         check($sformatf("conv%0d_data", i),  out_data,  64'(conv_tab[i].half));
         check($sformatf("conv%0d_flags", i), out_flags, conv_tab[i].flags);
         check($sformatf("conv%0d_mask", i),  out_mask,  4'h1);
      end

      // Partial flush, then the next vector restarts at lane 0.
      send(32'h40000000, 1'b0);
      send(32'h40400000, 1'b1);
      check("partial_data", out_data, 64'h0000_0000_4200_4000);
      check("partial_mask", out_mask, 4'h3);
      send(32'h3F800000, 1'b1);
      check("restart_data", out_data, 64'h0000_0000_0000_3C00);
      check("restart_mask", out_mask, 4'h1);
      step(1);

      // Backpressure: A occupies the output, B parks in HOLD.
      out_ready = 1'b0;
      foreach (vec_a[i]) send(vec_a[i], 1'b0);
      foreach (vec_b[i]) send(vec_b[i], 1'b0);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_data_a",   out_data, HALF_A);
      step(3);
      check("hold_still_a",   out_data,  HALF_A);
      check("hold_still_vld", out_valid, 1'b1);
      check("hold_still_rdy", in_ready,  1'b0);
      out_ready = 1'b1;
      step(1);
      check("pop_b_valid", out_valid, 1'b1);
      check("pop_b_data",  out_data,  HALF_B);
      check("pop_in_ready", in_ready, 1'b1);
      step(1);
      check("pop_drained", out_valid, 1'b0);

      // Reset after two accepts.
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b0);
      reset_pulse("rst_partial");
      foreach (vec_a[i]) send(vec_a[i], 1'b0);
      check("rst_partial_data", out_data, HALF_A);
      check("rst_partial_mask", out_mask, 4'hF);
      step(1);

      // Reset while a vector is held.
      out_ready = 1'b0;
      foreach (vec_a[i]) send(vec_a[i], 1'b0);
      foreach (vec_b[i]) send(vec_b[i], 1'b0);
      check("rst_hold_state", in_ready, 1'b0);
      reset_pulse("rst_hold");
      out_ready = 1'b1;
      foreach (vec_b[i]) send(vec_b[i], 1'b0);
      check("rst_hold_data", out_data, HALF_B);
      check("rst_hold_mask", out_mask, 4'hF);

      // Randomized traffic with random output backpressure and input gaps.
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               if ($urandom_range(0, 5) == 0) step(1);
               send(rand_fp(), $urandom_range(0, 5) == 0);
            end
            send(rand_fp(), 1'b1);
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
      check("drain_queue", 80'(exp_q.size()), 80'd0);
      check("drain_valid", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
